// File: rtl/logic_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_engine_pkg
// Description : Opcode constants, FSM state type and verdict helpers shared by
//               the logic opcode decoder and its match sub-module.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_engine_pkg;

  localparam int OP_W    = 2;
  localparam int NUM_OPS = 4;

  localparam logic [OP_W-1:0] OP_OR   = 2'b00;
  localparam logic [OP_W-1:0] OP_NAND = 2'b01;
  localparam logic [OP_W-1:0] OP_NOR  = 2'b10;
  localparam logic [OP_W-1:0] OP_AND  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index of the lowest set candidate bit; zero when no candidate survives.
  function automatic logic [OP_W-1:0] lowest_op(input logic [NUM_OPS-1:0] mask);
    lowest_op = '0;
    for (int k = NUM_OPS - 1; k >= 0; k--) begin
      if (mask[k]) lowest_op = k[OP_W-1:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/logic_op_match.sv
`default_nettype none
// ============================================================================
// Module      : logic_op_match
// Description : Combinational check of one observed result against all four
//               bitwise opcodes; bit k of m is set when opcode k explains r.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_op_match
  import logic_engine_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   r,
  output logic [NUM_OPS-1:0] m
);

  // A candidate must agree with the observed result on every bit.
  always_comb begin
    m          = '0;
    m[OP_OR]   = (r == (a | b));
    m[OP_NAND] = (r == ~(a & b));
    m[OP_NOR]  = (r == ~(a | b));
    m[OP_AND]  = (r == (a & b));
  end

endmodule
`default_nettype wire

// File: rtl/logic_opcode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : logic_opcode_decoder
// Description : Accumulates a trace of (a, b, r) samples, narrows the set of
//               opcodes consistent with all of them, and presents a
//               registered verdict with valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_opcode_decoder
  import logic_engine_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [WIDTH-1:0]   in_r,
  input  logic               in_last,
  input  logic               trace_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OPS-1:0] out_mask,
  output logic [OP_W-1:0]    out_opcode,
  output logic               out_unique,
  output logic               out_none,
  output logic [CNT_W-1:0]   out_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e               state_q, state_d;
  logic [NUM_OPS-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [NUM_OPS-1:0]   vmask_q, vmask_d;
  logic [OP_W-1:0]      vop_q, vop_d;
  logic                 vuniq_q, vuniq_d;
  logic                 vnone_q, vnone_d;
  logic [CNT_W-1:0]     vcount_q, vcount_d;

  logic [NUM_OPS-1:0]   m;
  logic                 xfer;
  logic                 load_verdict;

  logic_op_match #(.WIDTH(WIDTH)) u_match (
    .a (in_a),
    .b (in_b),
    .r (in_r),
    .m (m)
  );

  assign in_ready   = (state_q != ST_DONE) || out_ready;
  assign xfer       = in_valid && in_ready;
  assign out_valid  = (state_q == ST_DONE);
  assign out_mask   = vmask_q;
  assign out_opcode = vop_q;
  assign out_unique = vuniq_q;
  assign out_none   = vnone_q;
  assign out_count  = vcount_q;

  // Next-state, trace accumulation and verdict capture.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    count_d      = count_q;
    load_verdict = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_ACC: begin
        // Clear wins over a same-cycle sample, which is dropped.
        if (trace_clr) begin
          state_d = ST_IDLE;
          mask_d  = '0;
          count_d = '0;
        end else if (xfer) begin
          if (state_q == ST_IDLE) begin
            mask_d  = m;
            count_d = CNT_ONE;
          end else begin
            mask_d  = mask_q & m;
            count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
          end
          state_d      = in_last ? ST_DONE : ST_ACC;
          load_verdict = in_last;
        end
      end
      ST_DONE: begin
        // A transfer here implies out_ready, so the verdict is consumed and
        // the next trace opens in the same cycle.
        if (xfer) begin
          mask_d       = m;
          count_d      = CNT_ONE;
          state_d      = in_last ? ST_DONE : ST_ACC;
          load_verdict = in_last;
        end else if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    vmask_d  = vmask_q;
    vop_d    = vop_q;
    vuniq_d  = vuniq_q;
    vnone_d  = vnone_q;
    vcount_d = vcount_q;
    if (load_verdict) begin
      vmask_d  = mask_d;
      vop_d    = lowest_op(mask_d);
      vuniq_d  = ($countones(mask_d) == 1);
      vnone_d  = (mask_d == '0);
      vcount_d = count_d;
    end
  end

  // State, accumulator and verdict registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mask_q   <= '0;
      count_q  <= '0;
      vmask_q  <= '0;
      vop_q    <= '0;
      vuniq_q  <= 1'b0;
      vnone_q  <= 1'b0;
      vcount_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      count_q  <= count_d;
      vmask_q  <= vmask_d;
      vop_q    <= vop_d;
      vuniq_q  <= vuniq_d;
      vnone_q  <= vnone_d;
      vcount_q <= vcount_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_logic_opcode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_opcode_decoder
// Description : Directed self-checking bench for logic_opcode_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_opcode_decoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_b, in_r;
  logic       in_last;
  logic       trace_clr;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_mask;
  logic [1:0] out_opcode;
  logic       out_unique;
  logic       out_none;
  logic [7:0] out_count;

  int checks = 0;
  int errors = 0;

  logic_opcode_decoder #(.WIDTH(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_r       (in_r),
    .in_last    (in_last),
    .trace_clr  (trace_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_mask   (out_mask),
    .out_opcode (out_opcode),
    .out_unique (out_unique),
    .out_none   (out_none),
    .out_count  (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to 1 time unit after the next rising edge (input drive point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one sample for exactly one cycle (caller guarantees in_ready).
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] r,
                       input logic last, input logic clr);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_r      = r;
    in_last   = last;
    trace_clr = clr;
    step();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    trace_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_r = '0;
    in_last = 1'b0; trace_clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_mask !== 4'b0000) begin errors++; $display("FAIL reset_mask: got %b expected 0000", out_mask); end
    checks++; if (out_opcode !== 2'b00) begin errors++; $display("FAIL reset_opcode: got %b expected 00", out_opcode); end
    checks++; if (out_unique !== 1'b0) begin errors++; $display("FAIL reset_unique: got %b expected 0", out_unique); end
    checks++; if (out_none !== 1'b0) begin errors++; $display("FAIL reset_none: got %b expected 0", out_none); end
    checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", out_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    drive(8'h0F, 8'h33, 8'h3F, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    checks++; if (out_mask !== 4'b0001) begin errors++; $display("FAIL single_mask: got %b expected 0001", out_mask); end
    checks++; if (out_opcode !== 2'b00) begin errors++; $display("FAIL single_opcode: got %b expected 00", out_opcode); end
    checks++; if (out_unique !== 1'b1) begin errors++; $display("FAIL single_unique: got %b expected 1", out_unique); end
    checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", out_count); end
    step();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_consumed: got %b expected 0", out_valid); end
    step();
  endtask

  task automatic test_two_sample();
    drive(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL two_mid_valid: got %b expected 0", out_valid); end
    step();
    drive(8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL two_valid: got %b expected 1", out_valid); end
    checks++; if (out_mask !== 4'b0010) begin errors++; $display("FAIL two_mask: got %b expected 0010", out_mask); end
    checks++; if (out_opcode !== 2'b01) begin errors++; $display("FAIL two_opcode: got %b expected 01", out_opcode); end
    checks++; if (out_unique !== 1'b1) begin errors++; $display("FAIL two_unique: got %b expected 1", out_unique); end
    checks++; if (out_count !== 8'd2) begin errors++; $display("FAIL two_count: got %0d expected 2", out_count); end
    step();
  endtask

  task automatic test_none();
    drive(8'h00, 8'h00, 8'hAA, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (out_none !== 1'b1) begin errors++; $display("FAIL none_flag: got %b expected 1", out_none); end
    checks++; if (out_mask !== 4'b0000) begin errors++; $display("FAIL none_mask: got %b expected 0000", out_mask); end
    checks++; if (out_opcode !== 2'b00) begin errors++; $display("FAIL none_opcode: got %b expected 00", out_opcode); end
    checks++; if (out_unique !== 1'b0) begin errors++; $display("FAIL none_unique: got %b expected 0", out_unique); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    // a|b=FF, ~(a&b)=FF, ~(a|b)=00, a&b=00 -> NOR and AND
    drive(8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0);
    // Offer the next sample while the verdict is stalled.
    in_valid = 1'b1; in_a = 8'h0F; in_b = 8'h33; in_r = 8'h3F; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_mask !== 4'b1100 || out_opcode !== 2'b10 || out_count !== 8'd1)
        begin errors++; $display("FAIL hold_verdict[%0d]: got v=%b m=%b op=%b c=%0d expected v=1 m=1100 op=10 c=1", i, out_valid, out_mask, out_opcode, out_count); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d]: got %b expected 0", i, in_ready); end
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    step();
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_mask !== 4'b0001 || out_count !== 8'd1)
      begin errors++; $display("FAIL release_next: got v=%b m=%b c=%0d expected v=1 m=0001 c=1", out_valid, out_mask, out_count); end
    step();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_idle: got %b expected 0", out_valid); end
    step();
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_last = 1'b1;
    in_a = 8'h0F; in_b = 8'h33; in_r = 8'h3F;
    step();
    in_a = 8'h00; in_b = 8'h00; in_r = 8'hAA;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_mask !== 4'b0001) begin errors++; $display("FAIL b2b_first: got v=%b m=%b expected v=1 m=0001", out_valid, out_mask); end
    step();
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_none !== 1'b1) begin errors++; $display("FAIL b2b_second: got v=%b none=%b expected v=1 none=1", out_valid, out_none); end
    step();
  endtask

  task automatic test_reset_mid_trace();
    drive(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);
    drive(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_mask !== 4'b0000 || out_count !== 8'd0)
      begin errors++; $display("FAIL midreset_clear: got v=%b m=%b c=%0d expected v=0 m=0000 c=0", out_valid, out_mask, out_count); end
    step();
    rst_n = 1'b1;
    step();
    drive(8'hF0, 8'hF0, 8'hF0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (out_mask !== 4'b1001) begin errors++; $display("FAIL midreset_mask: got %b expected 1001", out_mask); end
    checks++; if (out_opcode !== 2'b00) begin errors++; $display("FAIL midreset_opcode: got %b expected 00", out_opcode); end
    checks++; if (out_unique !== 1'b0) begin errors++; $display("FAIL midreset_unique: got %b expected 0", out_unique); end
    checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL midreset_count: got %0d expected 1", out_count); end
    step();
  endtask

  task automatic test_saturation();
    logic [7:0] a, b;
    for (int i = 0; i < 300; i++) begin
      a = 8'(i);
      b = 8'(i * 7) ^ 8'h5A;
      drive(a, b, a | b, (i == 299), 1'b0);
    end
    @(negedge clk);
    checks++; if (out_count !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d expected 255", out_count); end
    checks++; if (out_mask !== 4'b0001) begin errors++; $display("FAIL sat_mask: got %b expected 0001", out_mask); end
    step();
  endtask

  task automatic test_trace_clr();
    drive(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);
    drive(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);
    drive(8'hFF, 8'hFF, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_no_verdict[%0d]: got %b expected 0", i, out_valid); end
      step();
    end
    // New trace after the clear starts fresh.
    drive(8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (out_mask !== 4'b1100 || out_count !== 8'd1)
      begin errors++; $display("FAIL clr_fresh: got m=%b c=%0d expected m=1100 c=1", out_mask, out_count); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_sample();
    test_none();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_trace();
    test_saturation();
    test_trace_clr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/logic_opcode_decoder.md
LOGIC_OPCODE_DECODER -- requirements
Module: logic_opcode_decoder

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits.
REQ-002 Parameter CNT_W, default 8: width of the sample counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  sample on in_a/in_b/in_r/in_last is valid.
REQ-006 in_ready  output  1  decoder accepts the sample this cycle.
REQ-007 in_a, in_b  input  WIDTH each  operands applied to the logic engine.
REQ-008 in_r  input  WIDTH  result observed from the logic engine.
REQ-009 in_last  input  1  final sample of the current trace.
REQ-010 trace_clr  input  1  synchronous discard of the open trace.
REQ-011 out_valid  output  1  verdict available.
REQ-012 out_ready  input  1  consumer takes the verdict.
REQ-013 out_mask  output  4  candidate opcodes; bit k set means opcode k is consistent with every sample.
REQ-014 out_opcode  output  2  lowest-index set bit of out_mask; 2'b00 when out_mask is 0.
REQ-015 out_unique  output  1  exactly one bit of out_mask set.
REQ-016 out_none  output  1  out_mask is 0 (trace inconsistent with every opcode).
REQ-017 out_count  output  CNT_W  number of samples in the trace, saturating.

Function
REQ-018 Opcode encoding SHALL be 00 OR, 01 NAND, 10 NOR, 11 AND, applied bitwise over all WIDTH bits.
REQ-019 The per-sample match vector m[k] SHALL be 1 iff in_r equals opcode k applied to in_a and in_b, across all WIDTH bits.
REQ-020 A transfer SHALL occur when in_valid and in_ready are both 1.
REQ-021 FSM states SHALL be IDLE (no trace open), ACC (trace open), and DONE (verdict held).
REQ-022 In IDLE, a transfer SHALL load mask = m and count = 1; the FSM moves to DONE if in_last is 1, otherwise to ACC.
REQ-023 In ACC, a transfer SHALL set mask = mask & m and increment count, saturating at 2^CNT_W-1; the FSM moves to DONE on in_last.
REQ-024 out_valid SHALL rise in the cycle after the in_last transfer (latency 1).
REQ-025 The verdict outputs SHALL be registered values of the final mask and count.
REQ-026 The verdict outputs SHALL hold stable while out_valid is 1 and out_ready is 0.
REQ-027 in_ready SHALL be 1 in IDLE and ACC, and equal to out_ready in DONE.
REQ-028 A transfer in DONE with out_ready 1 SHALL open a new trace exactly as in IDLE, with no bubble cycle.
REQ-029 DONE SHALL go to IDLE when out_ready is 1 and no transfer occurs.
REQ-030 trace_clr SHALL take priority over a same-cycle transfer in IDLE or ACC: the sample is dropped, the FSM goes to IDLE, and mask and count are cleared.
REQ-031 trace_clr SHALL be ignored in DONE.
REQ-032 A single-sample trace (in_last on the first sample) SHALL be legal.

Reset
REQ-033 While rst_n is 0, the FSM SHALL be IDLE; out_valid, out_mask, out_opcode, out_unique, out_count and internal mask/count SHALL be 0; out_none SHALL be 0.
REQ-034 Reset asserted mid-trace or during DONE SHALL discard all trace and verdict state.

Structure
REQ-035 Shared package logic_engine_pkg SHALL hold the opcode constants (OP_OR, OP_NAND, OP_NOR, OP_AND) and the opcode width.
REQ-036 One combinational sub-module, logic_op_match, SHALL compute the 4-bit match vector m from a, b and r.

Verification
REQ-037 Single-sample trace a=0x0F, b=0x33, r=0x3F, last -> next cycle out_mask=0001, out_opcode=00, out_unique=1, out_count=1.
REQ-038 First trace: a=0xFF, b=0x00, r=0xFF (not last), which matches OR and NAND. Second sample: a=0xFF, b=0xFF, r=0x00, last -> out_mask=0010, out_opcode=01, out_unique=1, out_count=2.
REQ-039 Sample a=0x00, b=0x00, r=0xAA, last -> out_none=1, out_mask=0000, out_opcode=00.
REQ-040 Hold out_ready at 0 for 5 cycles after a verdict -> outputs stable and in_ready=0; raise out_ready with in_valid=1 -> that sample is accepted the same cycle and the next trace starts.
REQ-041 Assert rst_n=0 after 2 samples, then send a=0xF0, b=0xF0, r=0xF0, last -> out_mask=1001, out_opcode=00, out_unique=0, out_count=1.
REQ-042 Send 300 consistent OR samples with CNT_W=8 -> out_count=255, out_mask=0001; separately, trace_clr together with the final sample -> no verdict is produced.
